// File: rtl/frame_rotator.sv
`default_nettype none
// ============================================================================
// Module   : frame_rotator
// Purpose  : Rotates NUM_FRAMES frame buffers between the input write DMA and
//            the output read DMA: collision avoidance, latest-frame selection,
//            drop/repeat, interlaced pairing and input-loss timeout.
//            Define FRAME_ROTATOR_STATS_EN to build the drop/repeat counters.
// Revision : 1.0 - initial release
// ============================================================================
module frame_rotator #(
    parameter int NUM_FRAMES     = 4,
    parameter int FRAME_BITS     = 2,
    parameter int INTERLACE      = 1,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  vin_vs,
    input  logic                  vin_f,
    input  logic                  vout_vs,
    input  logic                  freeze,
    input  logic                  stat_clr,
    output logic [FRAME_BITS-1:0] wr_frame_addr,
    output logic [FRAME_BITS-1:0] rd_frame_addr,
    output logic                  frame_wr_start,
    output logic                  frame_rd_start,
    output logic                  vin_lost,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           repeat_cnt
);

    localparam int                    c_to_w     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0]     c_to_max   = c_to_w'(TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0]     c_to_one   = c_to_w'(1);
    localparam logic [FRAME_BITS-1:0] c_last     = FRAME_BITS'(NUM_FRAMES - 1);
    localparam logic [FRAME_BITS-1:0] c_fr_one   = FRAME_BITS'(1);
    localparam logic [0:0]            c_w_idle   = 1'b0;
    localparam logic [0:0]            c_w_active = 1'b1;

    function automatic logic [FRAME_BITS-1:0] f_inc(input logic [FRAME_BITS-1:0] x);
        return (x == c_last) ? '0 : x + c_fr_one;
    endfunction

    logic                  r_vin_vs_meta, r_vin_vs_sync, r_vin_vs_prev;
    logic                  r_vin_f_meta, r_vin_f_sync;
    logic                  r_vout_vs_meta, r_vout_vs_sync, r_vout_vs_prev;
    logic [0:0]            r_wstate;
    logic [FRAME_BITS-1:0] r_latest;
    logic                  r_latest_valid;
    logic [c_to_w-1:0]     r_to_cnt;

    logic                  w_vin_edge, w_vout_edge;
    logic                  w_read_take, w_read_rep, w_commit, w_drop;
    logic [FRAME_BITS-1:0] w_new_rd, w_c1, w_next_wr;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            r_vin_vs_meta  <= 1'b0;
            r_vin_vs_sync  <= 1'b0;
            r_vin_vs_prev  <= 1'b0;
            r_vin_f_meta   <= 1'b0;
            r_vin_f_sync   <= 1'b0;
            r_vout_vs_meta <= 1'b0;
            r_vout_vs_sync <= 1'b0;
            r_vout_vs_prev <= 1'b0;
        end else begin
            r_vin_vs_meta  <= vin_vs;
            r_vin_vs_sync  <= r_vin_vs_meta;
            r_vin_vs_prev  <= r_vin_vs_sync;
            r_vin_f_meta   <= vin_f;
            r_vin_f_sync   <= r_vin_f_meta;
            r_vout_vs_meta <= vout_vs;
            r_vout_vs_sync <= r_vout_vs_meta;
            r_vout_vs_prev <= r_vout_vs_sync;
        end
    end

    assign w_vin_edge  = r_vin_vs_sync & ~r_vin_vs_prev;
    assign w_vout_edge = r_vout_vs_sync & ~r_vout_vs_prev;

    // The read resolves first; the commit then steers around its result.
    assign w_read_take = w_vout_edge & ~freeze & r_latest_valid;
    assign w_read_rep  = w_vout_edge & ~freeze & ~r_latest_valid;
    assign w_new_rd    = w_read_take ? r_latest : rd_frame_addr;
    assign w_commit    = w_vin_edge & (r_wstate == c_w_active) &
                         ((INTERLACE == 0) | r_vin_f_sync);
    assign w_c1        = f_inc(wr_frame_addr);
    assign w_next_wr   = (w_c1 == w_new_rd) ? f_inc(w_c1) : w_c1;
    assign w_drop      = w_commit & r_latest_valid & ~w_read_take;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            r_wstate       <= c_w_idle;
            wr_frame_addr  <= '0;
            rd_frame_addr  <= '0;
            r_latest       <= '0;
            r_latest_valid <= 1'b0;
            frame_wr_start <= 1'b0;
            frame_rd_start <= 1'b0;
            vin_lost       <= 1'b0;
            r_to_cnt       <= '0;
        end else begin
            frame_wr_start <= w_vin_edge;
            frame_rd_start <= w_vout_edge;
            if (w_vout_edge && !freeze) begin
                rd_frame_addr <= w_new_rd;
            end
            if (w_commit) begin
                r_latest       <= wr_frame_addr;
                wr_frame_addr  <= w_next_wr;
                r_latest_valid <= 1'b1;
            end else if (w_read_take) begin
                r_latest_valid <= 1'b0;
            end
            // A vin edge in the saturating cycle wins and keeps the writer alive.
            if (w_vin_edge) begin
                r_to_cnt <= '0;
                vin_lost <= 1'b0;
                r_wstate <= c_w_active;
            end else if (r_to_cnt != c_to_max) begin
                r_to_cnt <= r_to_cnt + c_to_one;
                if (r_to_cnt == c_to_max - c_to_one) begin
                    vin_lost <= 1'b1;
                    r_wstate <= c_w_idle;
                end
            end
        end
    end

`ifdef FRAME_ROTATOR_STATS_EN
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else if (stat_clr) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else begin
            if (w_drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (w_read_rep && repeat_cnt != 16'hFFFF) begin
                repeat_cnt <= repeat_cnt + 16'd1;
            end
        end
    end
`else
    logic w_unused_stats;
    assign w_unused_stats = stat_clr ^ w_drop ^ w_read_rep;
    assign drop_cnt       = '0;
    assign repeat_cnt     = '0;
`endif

endmodule
`default_nettype wire

// File: doc/frame_rotator.md
# frame_rotator

Frame-buffer rotation controller for the video pipeline. Runs in the `mem_clk` domain between the video-input write DMA and the video-output read DMA. Generalises fixed 4-frame write-index rotation to `NUM_FRAMES` buffers and adds:
- writer/reader collision avoidance;
- latest-frame selection, frame drop and frame repeat;
- interlaced frame pairing;
- input-loss timeout and read freeze.

## Interface
Parameters:
- `NUM_FRAMES`, 4: number of frame buffers; legal 3..16; wrap is `NUM_FRAMES-1`→0, not power-of-two dependent.
- `FRAME_BITS`, 2: width of the frame index; must satisfy `2**FRAME_BITS >= NUM_FRAMES`.
- `INTERLACE`, 1: 1 = a frame is two fields, commit only at end of field with f=1; 0 = progressive.
- `TIMEOUT_CYCLES`, 2000000: `mem_clk` cycles without an input vs edge before input is declared lost.

Ports (one clock; reset is asynchronous and active-high):
- `mem_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vin_vs`  in  1  input vsync, asynchronous; synchronised internally.
- `vin_f`  in  1  input field flag, asynchronous; synchronised alongside `vin_vs`.
- `vout_vs`  in  1  output vsync, asynchronous; synchronised internally.
- `freeze`  in  1  synchronous level; 1 holds `rd_frame_addr`.
- `stat_clr`  in  1  synchronous pulse; clears statistics.
- `wr_frame_addr`  out  FRAME_BITS  buffer index the writer fills.
- `rd_frame_addr`  out  FRAME_BITS  buffer index the reader displays.
- `frame_wr_start`  out  1  one-cycle pulse; writer restarts at field/frame start.
- `frame_rd_start`  out  1  one-cycle pulse; reader restarts.
- `vin_lost`  out  1  input timeout flag.
- `drop_cnt`  out  16  frames committed but never displayed.
- `repeat_cnt`  out  16  output frames that re-showed an old buffer.

## Operation
- Synchronisers: 2-FF for each of `vin_vs`, `vin_f` and `vout_vs`. The rising edge is detected on the synchronised output; `f_s` is the synchronised `vin_f` at the detected edge.
- Internal state:
  - `latest[FRAME_BITS]`: last committed buffer.
  - `latest_valid`: a committed buffer has not yet been displayed.
- Writer FSM: W_IDLE, W_ACTIVE.
  - W_IDLE + vin edge → W_ACTIVE. Pulse `frame_wr_start`, no commit, `wr_frame_addr` unchanged.
  - W_ACTIVE + vin edge → pulse `frame_wr_start`. If `INTERLACE==0` or `f_s==1`, commit.
  - Any state + timeout → W_IDLE, `vin_lost`=1. The partial frame is discarded and no commit occurs.
- Commit:
  - `latest`←`wr_frame_addr`, `latest_valid`←1.
  - If `latest_valid` was already 1 and the same-cycle read did not consume it, `drop_cnt`++.
  - Next write index: c1=inc(`wr_frame_addr`). If c1==`new_rd`, use inc(c1). This never equals `new_rd` or the just-committed buffer because `NUM_FRAMES`≥3.
- Read event (vout edge):
  - Always pulse `frame_rd_start`.
  - `freeze`=1: hold `rd_frame_addr`; no counter change.
  - Else if `latest_valid`: `new_rd`=`latest`, `latest_valid`←0.
  - Else: `new_rd`=`rd_frame_addr`, `repeat_cnt`++.
- Simultaneous read and commit in one cycle: the read resolves first against the pre-commit `latest`. The commit then skips the resulting `new_rd` and sets `latest_valid`=1 with the new buffer. No drop is counted in this case.
- Timeout counter:
  - Cleared on every vin edge; otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - `vin_lost`=1 while saturated; cleared on the next vin edge.
  - While lost, the reader keeps repeating `rd_frame_addr`.
- Counters: 16-bit, saturate at 0xFFFF. `stat_clr` zeroes both counters and wins over a same-cycle increment.

## Timing
- Reset values: `wr_frame_addr`=0, `rd_frame_addr`=0, `latest`=0, `latest_valid`=0, pulses 0, `vin_lost`=0, counters 0, FSM=W_IDLE, timeout counter 0, synchronisers 0.
- Latency: if vs is first sampled high at edge k, the registered outputs (pulse, addresses, counters) update at edge k+2. The pulse is high for exactly one cycle.
- Vs edges must be spaced ≥4 cycles. Closer edges may merge.
- `freeze` and `stat_clr` take effect on the edge at which they are sampled.
- Reset mid-frame returns all state to reset values immediately, with no commit. The first post-reset vin edge only starts the writer.

## Configuration
- `FRAME_ROTATOR_STATS_EN` defined: drop/repeat counters and `stat_clr` are implemented as specified.
- Not defined: `drop_cnt`/`repeat_cnt` are tied to 0 and `stat_clr` is ignored. Rotation behaviour is identical.

## Test plan
- Progressive, `NUM_FRAMES`=4, input 120 Hz, output 60 Hz → `wr_frame_addr` steps 0,1,2,3,... skipping `rd_frame_addr`. Reader always shows the newest commit. `drop_cnt`=1 per output frame; `repeat_cnt`=0.
- Progressive, input 30 Hz, output 60 Hz → every other read repeats; after 10 input frames, `repeat_cnt`≈10 and `drop_cnt`=0. Writer never equals reader.
- `INTERLACE`=1, fields alternating f=0/1 → commit only after f=1 fields. `frame_wr_start` pulses every field; `wr_frame_addr` changes every second field.
- Vin edge and vout edge detected in the same cycle, with `latest`=2, wr=3 and `NUM_FRAMES`=4 → rd=2, new wr=0, `latest`=3 with `latest_valid`=1, no drop.
- Stop `vin_vs`, `TIMEOUT_CYCLES`=100 → `vin_lost`=1 at cycle 100 and reads repeat. On the next vin edge: `vin_lost`=0, no commit, wr unchanged.
- `freeze`=1 across 3 reads with active input → `rd_frame_addr` constant, `repeat_cnt` unchanged, writer rotates over the other 3 buffers. Assert `rst` mid-frame → all outputs return to 0 asynchronously.
